mc_control: RTL
===============

Name: mc_control

Overview:
- Multi-cycle main control FSM for the MIPS-subset datapath. Successor to the single-cycle combinational decoder.
- Sequences FETCH/DECODE/EXEC/MEM/WB per instruction and honours a memory-ready handshake.
- Flags illegal opcodes and counts retired instructions.
- Sits between the instruction register fields and the shared-memory multi-cycle datapath.

Parameters:
- MEM_HANDSHAKE, 1, 1 = memory states wait for mem_ready; 0 = mem_ready ignored (single-cycle memory).
- CNT_W, 32, width of the retired-instruction counter.
- ALUOP_W, 4, width of alu_op; must be >= 4, upper bits driven 0.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  6  IR[31:26]
- funct  in  6  IR[5:0], used for jr
- rt  in  5  IR[20:16], selects bgez/bltz
- mem_ready  in  1  memory access completes this cycle
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load if the branch condition holds
- branch_type  out  3  001 beq, 010 bne, 011 bgtz, 100 bgez, 101 bltz, 000 none
- pc_src  out  2  00 ALU result, 01 ALUOut, 10 jump target, 11 rs (jr)
- iord  out  1  0 = PC address, 1 = ALUOut address
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- ir_write  out  1  IR load
- reg_dst  out  2  00 rt, 01 rd, 10 $31
- mem_to_reg  out  2  00 ALUOut, 01 MDR, 10 PC
- reg_write  out  1  register file write
- alu_src_a  out  1  0 PC, 1 A
- alu_src_b  out  2  00 B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
- alu_op  out  ALUOP_W  00=add, 04=R-type, 06=addi, 0C=andi, 08=beq/bne, 03=bgtz, 09=bgez, 01=bltz (hex)
- illegal  out  1  one-cycle pulse on an unsupported opcode
- instr_count  out  CNT_W  retired instructions, wraps
- state  out  4  current state code (debug)

Behaviour:
- Moore FSM; all outputs decode from state, plus a registered decode latch captured in DECODE. No combinational path from inputs to outputs except pc_write/ir_write in FETCH, which are gated by mem_ready.
- Async reset (rst_n=0): state=RESET(0), instr_count=0, every control output 0. The first rising edge with rst_n=1 goes to FETCH.
- Reset mid-instruction forces RESET immediately; mem_write and reg_write drop asynchronously.
- Default values in every state: strobes 0, alu_op=add, selects 00.
- FETCH(1): mem_read=1, iord=0, alu_src_a=0, alu_src_b=01.
  - ir_write=pc_write=mem_ready, pc_src=00.
  - Stays in FETCH while mem_ready=0; otherwise goes to DECODE.
- DECODE(2): alu_src_b=11, alu_op=add (branch target into ALUOut); latches the instruction class. Dispatch:
  - lw/sw -> MEMADR
  - R-type with funct!=0x08 -> EXEC
  - R-type with funct=0x08 -> JR
  - addi/andi -> IEXEC
  - beq/bne/bgtz -> BRANCH
  - opcode 0x01 with rt=1 or rt=0 -> BRANCH
  - j/jal -> JUMP
  - anything else (including opcode 0x01 with any other rt) -> ILLEGAL
- MEMADR(3): alu_src_a=1, alu_src_b=10, add. Goes to MEMRD for lw, MEMWR for sw.
- MEMRD(4): mem_read=1, iord=1. Waits on mem_ready, then goes to MEMWB.
- MEMWB(5): reg_write=1, reg_dst=00, mem_to_reg=01. Retires; goes to FETCH.
- MEMWR(6): mem_write=1, iord=1. Held until mem_ready, then retires and goes to FETCH.
- EXEC(7): alu_src_a=1, alu_src_b=00, alu_op=04. Goes to RWB.
- RWB(8): reg_write=1, reg_dst=01. Retires.
- IEXEC(9): alu_src_a=1, alu_src_b=10, alu_op=06 (addi) or 0C (andi). Goes to IWB.
- IWB(10): reg_write=1, reg_dst=00. Retires.
- BRANCH(11): alu_src_a=1, pc_write_cond=1, pc_src=01, branch_type per instruction.
  - beq/bne: alu_src_b=00.
  - zero-compare branches: alu_src_b=10.
  - alu_op per the table above. Retires.
- JUMP(12): pc_write=1, pc_src=10.
  - jal additionally: reg_write=1, reg_dst=10, mem_to_reg=10.
  - Retires.
- JR(13): pc_write=1, pc_src=11. Retires.
- ILLEGAL(14): illegal=1 for one cycle, no writes. Counts as retired; goes to FETCH.
- Unused code 15: goes to FETCH with outputs 0.
- Latency with mem_ready always 1:
  - lw 5 cycles
  - sw, R-type, addi, andi 4 cycles
  - branch, j, jal, jr, illegal 3 cycles
- Each cycle mem_ready=0 in FETCH/MEMRD/MEMWR adds one cycle.
- MEM_HANDSHAKE=0: mem_ready treated as 1.
- instr_count: +1 on the edge leaving each retiring state. Wraps from 2^CNT_W-1 to 0.
- mem_ready outside memory states is ignored.

Test Plan:
- Reset: rst_n=0 -> all outputs 0, state=0, instr_count=0. First edge after release -> state=1, mem_read=1.
- lw (opcode 0x23), mem_ready=1 -> states 1,2,3,4,5.
  - MEMWB: reg_write=1, mem_to_reg=01.
  - instr_count 0->1 after 5 cycles.
- sw (0x2B) with mem_ready low for 3 cycles in MEMWR -> mem_write held 4 cycles, then FETCH; total 7 cycles.
- bgez (0x01, rt=1) -> BRANCH with branch_type=100, alu_op=0x9, alu_src_b=10.
  - Same opcode with rt=0 -> branch_type=101, alu_op=0x1.
  - Same opcode with rt=2 -> illegal pulse, no writes.
- jal (0x03) -> JUMP: pc_write=1, pc_src=10, reg_write=1, reg_dst=10, mem_to_reg=10.
  - jr (0x00, funct 0x08) -> JR: pc_src=11, reg_write=0.
- R-type add, with rst_n pulsed low during EXEC -> state=0 immediately, reg_write never asserts. Then preload instr_count=2^CNT_W-1 (CNT_W=4) and retire one instruction -> instr_count=0.

Source files
------------

// File: rtl/mc_control_if.sv
// Memory-side handshake bundle between the multi-cycle control FSM and memory.
// Ports: mem_ready (memory -> control), mem_read/mem_write/iord (control -> memory).
interface mc_control_if;
    logic mem_ready;
    logic mem_read;
    logic mem_write;
    logic iord;

    modport master (
        input  mem_ready,
        output mem_read,
        output mem_write,
        output iord
    );

    modport slave (
        output mem_ready,
        input  mem_read,
        input  mem_write,
        input  iord
    );
endinterface

// File: rtl/mc_control.sv
// Multi-cycle main control FSM for the MIPS-subset shared-memory datapath.
// Ports: clk, rst_n, IR fields (opcode/funct/rt), memory bundle (mem), datapath
// controls, illegal pulse, retired-instruction counter and debug state code.
module mc_control #(
    parameter int MEM_HANDSHAKE = 1,
    parameter int CNT_W         = 32,
    parameter int ALUOP_W       = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    input  logic [4:0]         rt,
    mc_control_if.master       mem,
    output logic               pc_write,
    output logic               pc_write_cond,
    output logic [2:0]         branch_type,
    output logic [1:0]         pc_src,
    output logic               ir_write,
    output logic [1:0]         reg_dst,
    output logic [1:0]         mem_to_reg,
    output logic               reg_write,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [ALUOP_W-1:0] alu_op,
    output logic               illegal,
    output logic [CNT_W-1:0]   instr_count,
    output logic [3:0]         state
);

    typedef enum logic [3:0] {
        S_RESET   = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_MEMADR  = 4'd3,
        S_MEMRD   = 4'd4,
        S_MEMWB   = 4'd5,
        S_MEMWR   = 4'd6,
        S_EXEC    = 4'd7,
        S_RWB     = 4'd8,
        S_IEXEC   = 4'd9,
        S_IWB     = 4'd10,
        S_BRANCH  = 4'd11,
        S_JUMP    = 4'd12,
        S_JR      = 4'd13,
        S_ILLEGAL = 4'd14
    } state_t;

    typedef enum logic [3:0] {
        K_LW, K_SW, K_R, K_JR, K_ADDI, K_ANDI,
        K_BEQ, K_BNE, K_BGTZ, K_BGEZ, K_BLTZ,
        K_J, K_JAL, K_ILL
    } kind_t;

    state_t           state_q, state_d;
    kind_t            kind_q, kind_d, kind_c;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ready;
    logic             retire;

    logic             mem_read_c;
    logic             mem_write_c;
    logic             iord_c;
    logic [3:0]       alu_op_c;

    // With a single-cycle memory the handshake is tied off.
    assign ready = (MEM_HANDSHAKE == 0) ? 1'b1 : mem.mem_ready;

    // Instruction class from the IR fields; only sampled in DECODE.
    always_comb begin
        kind_c = K_ILL;
        case (opcode)
            6'h23: kind_c = K_LW;
            6'h2B: kind_c = K_SW;
            6'h00: kind_c = (funct == 6'h08) ? K_JR : K_R;
            6'h08: kind_c = K_ADDI;
            6'h0C: kind_c = K_ANDI;
            6'h04: kind_c = K_BEQ;
            6'h05: kind_c = K_BNE;
            6'h07: kind_c = K_BGTZ;
            6'h01: begin
                if (rt == 5'd1)
                    kind_c = K_BGEZ;
                else if (rt == 5'd0)
                    kind_c = K_BLTZ;
                else
                    kind_c = K_ILL;
            end
            6'h02: kind_c = K_J;
            6'h03: kind_c = K_JAL;
            default: kind_c = K_ILL;
        endcase
    end

    // Next state and retire detection.
    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        kind_d  = kind_q;
        case (state_q)
            S_RESET: state_d = S_FETCH;
            S_FETCH: begin
                if (ready)
                    state_d = S_DECODE;
            end
            S_DECODE: begin
                kind_d = kind_c;
                case (kind_c)
                    K_LW, K_SW:      state_d = S_MEMADR;
                    K_R:             state_d = S_EXEC;
                    K_JR:            state_d = S_JR;
                    K_ADDI, K_ANDI:  state_d = S_IEXEC;
                    K_BEQ, K_BNE,
                    K_BGTZ, K_BGEZ,
                    K_BLTZ:          state_d = S_BRANCH;
                    K_J, K_JAL:      state_d = S_JUMP;
                    default:         state_d = S_ILLEGAL;
                endcase
            end
            S_MEMADR: state_d = (kind_q == K_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD: begin
                if (ready)
                    state_d = S_MEMWB;
            end
            S_MEMWR: begin
                if (ready) begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end
            end
            S_EXEC:  state_d = S_RWB;
            S_IEXEC: state_d = S_IWB;
            S_MEMWB, S_RWB, S_IWB, S_BRANCH,
            S_JUMP, S_JR, S_ILLEGAL: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
        cnt_d = retire ? cnt_q + CNT_W'(1) : cnt_q;
    end

    // Moore output decode; FETCH strobes alone follow mem_ready.
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        branch_type   = 3'b000;
        pc_src        = 2'b00;
        mem_read_c    = 1'b0;
        mem_write_c   = 1'b0;
        iord_c        = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = 2'b00;
        mem_to_reg    = 2'b00;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op_c      = 4'h0;
        illegal       = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read_c = 1'b1;
                alu_src_b  = 2'b01;
                ir_write   = ready;
                pc_write   = ready;
            end
            S_DECODE: alu_src_b = 2'b11;
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                mem_read_c = 1'b1;
                iord_c     = 1'b1;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 2'b01;
            end
            S_MEMWR: begin
                mem_write_c = 1'b1;
                iord_c      = 1'b1;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op_c  = 4'h4;
            end
            S_RWB: begin
                reg_write = 1'b1;
                reg_dst   = 2'b01;
            end
            S_IEXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op_c  = (kind_q == K_ANDI) ? 4'hC : 4'h6;
            end
            S_IWB: reg_write = 1'b1;
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                pc_write_cond = 1'b1;
                pc_src        = 2'b01;
                alu_src_b     = 2'b10;
                case (kind_q)
                    K_BEQ: begin
                        branch_type = 3'b001;
                        alu_op_c    = 4'h8;
                        alu_src_b   = 2'b00;
                    end
                    K_BNE: begin
                        branch_type = 3'b010;
                        alu_op_c    = 4'h8;
                        alu_src_b   = 2'b00;
                    end
                    K_BGTZ: begin
                        branch_type = 3'b011;
                        alu_op_c    = 4'h3;
                    end
                    K_BGEZ: begin
                        branch_type = 3'b100;
                        alu_op_c    = 4'h9;
                    end
                    default: begin
                        branch_type = 3'b101;
                        alu_op_c    = 4'h1;
                    end
                endcase
            end
            S_JUMP: begin
                pc_write = 1'b1;
                pc_src   = 2'b10;
                if (kind_q == K_JAL) begin
                    reg_write  = 1'b1;
                    reg_dst    = 2'b10;
                    mem_to_reg = 2'b10;
                end
            end
            S_JR: begin
                pc_write = 1'b1;
                pc_src   = 2'b11;
            end
            S_ILLEGAL: illegal = 1'b1;
            default: ;
        endcase
    end

    assign mem.mem_read  = mem_read_c;
    assign mem.mem_write = mem_write_c;
    assign mem.iord      = iord_c;
    assign alu_op        = ALUOP_W'(alu_op_c);
    assign instr_count   = cnt_q;
    assign state         = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RESET;
            kind_q  <= K_ILL;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
